rv32i_wb_stage: RTL
===================

// Module: rv32i_wb_stage
// PURPOSE
//   Writeback stage of the 5-stage RV32I pipeline, directly downstream of the memory stage.
//   Aligns the memory-stage source select with synchronous RAM/IO read data.
//   Formats load data (byte/half/word, sign/zero extend) and drives the register-file write port.
//   Provides two forwarding taps (current WB, one-cycle-delayed WB) and a retired-instruction counter.
// PARAMETERS
//   INSTRET_W   64   width of retired-instruction counter (wraps modulo 2^INSTRET_W)
// PORTS
//   clk               in   1   system clock
//   reset             in   1   synchronous reset, active high
//   pc_in             in   32  PC of instruction in WB (registered by mem stage)
//   iw_in             in   32  instruction word in WB (0 = bubble)
//   alu_in            in   32  ALU result / effective address in WB
//   wb_en_in          in   1   register writeback requested
//   wb_reg_in         in   5   destination register
//   src_sel_in        in   2   mem-stage source select, combinational, belongs to NEXT WB instr
//   memif_rdata_in    in   32  RAM read data, valid in WB cycle (1-cycle sync read)
//   io_rdata_in       in   32  IO read data, valid in WB cycle (1-cycle sync read)
//   regif_wb_enable   out  1   register-file write enable
//   regif_wb_reg      out  5   register-file write address
//   regif_wb_data     out  32  register-file write data
//   df_wb_enable      out  1   forward tap: = regif_wb_enable
//   df_wb_reg         out  5   forward tap: = regif_wb_reg
//   df_wb_data        out  32  forward tap: = regif_wb_data
//   df_wbd_enable     out  1   registered copy of df_wb_enable (covers RF write-then-read edge)
//   df_wbd_reg        out  5   registered copy of df_wb_reg
//   df_wbd_data       out  32  registered copy of df_wb_data
//   instret           out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//   - src_sel_q <= src_sel_in each clk; reset value 2'd2 (ALU). Encoding: 0 RAM, 1 IO, 2 ALU, 3 = ALU.
//   - is_load = (iw_in[6:0]==7'b0000011); non-load always selects alu_in regardless of src_sel_q.
//   - Load raw = src_sel_q==0 ? memif_rdata_in : src_sel_q==1 ? io_rdata_in : alu_in.
//   - Offset off = alu_in[1:0]; funct3 = iw_in[14:12]:
//       000 LB : sext(raw[8*off +: 8])       100 LBU: zext(raw[8*off +: 8])
//       001 LH : sext(raw[16*off[1] +: 16])  101 LHU: zext(raw[16*off[1] +: 16]); off[0] ignored
//       010 LW : raw, off ignored            other funct3: raw unchanged
//   - regif_wb_enable = !reset && wb_en_in && (wb_reg_in != 0); x0 never written.
//   - regif_wb_reg = wb_reg_in; regif_wb_data = formatted value; all combinational, 0 latency.
//   - df_wbd_*: registered from df_wb_* each clk; reset values 0/0/0.
//   - instret: reset 0; +1 on each non-reset clk where iw_in != 0; wraps all-ones -> 0.
//   - Reset mid-operation: counter, src_sel_q and df_wbd_* take reset values next edge;
//     regif_wb_enable forced 0 during reset cycle even if wb_en_in=1.
//   - First WB cycle after reset uses src_sel_q=ALU (pipeline carries bubble, iw_in=0).
// TESTING
//   1 LB, alu_in=..03, mem=0x80AA5511, src_sel=0 prev cycle -> regif_wb_data=0xFFFFFF80, enable=1.
//   2 LHU, off=2, mem=0xBEEF1234 -> 0x0000BEEF; LH same -> 0xFFFFBEEF; LW off=3 -> 0xBEEF1234.
//   3 IO load: src_sel_in=1 then io_rdata=0x0000007F, LBU off=0 -> 0x7F; mem data ignored.
//   4 ADDI wb_reg=0, wb_en=1 -> enable=0; wb_reg=5, alu=0x1234 -> enable=1, df_wbd_* =5/0x1234 next clk.
//   5 10 nonzero iw then 2 bubbles -> instret=10; preload near wrap (INSTRET_W=4): 15+1 -> 0.
//   6 reset asserted with wb_en_in=1 -> enable=0, instret=0, df_wbd_enable=0 after edge.

Source files
------------

// File: rtl/rv32i_wb_stage.sv
// Writeback stage of the RV32I pipeline: aligns the memory-stage source select with
// synchronous read data, formats loads, drives the register-file write port and forwarding taps.
module rv32i_wb_stage #(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          iw_in,
    input  logic [31:0]          alu_in,
    input  logic                 wb_en_in,
    input  logic [4:0]           wb_reg_in,
    input  logic [1:0]           src_sel_in,
    input  logic [31:0]          memif_rdata_in,
    input  logic [31:0]          io_rdata_in,
    output logic                 regif_wb_enable,
    output logic [4:0]           regif_wb_reg,
    output logic [31:0]          regif_wb_data,
    output logic                 df_wb_enable,
    output logic [4:0]           df_wb_reg,
    output logic [31:0]          df_wb_data,
    output logic                 df_wbd_enable,
    output logic [4:0]           df_wbd_reg,
    output logic [31:0]          df_wbd_data,
    output logic [INSTRET_W-1:0] instret
);

    logic [1:0]           src_sel_r;
    logic                 wbd_enable_r;
    logic [4:0]           wbd_reg_r;
    logic [31:0]          wbd_data_r;
    logic [INSTRET_W-1:0] instret_r;

    logic                 is_load_s;
    logic [31:0]          raw_s;
    logic [7:0]           byte_s;
    logic [15:0]          half_s;
    logic [31:0]          load_s;
    logic [31:0]          wb_data_s;
    logic                 wb_enable_s;
    logic                 unused_s;

    // PC and the non-funct3 instruction fields play no part in writeback.
    assign unused_s = ^{pc_in, iw_in[31:15], iw_in[11:7]};

    // Source select arrives one cycle ahead of the read data it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_sel_r <= 2'd2;
        end else begin
            src_sel_r <= src_sel_in;
        end
    end

    // Load source selection and byte/half extraction with sign or zero extension.
    always_comb begin
        is_load_s = (iw_in[6:0] == 7'b0000011);
        case (src_sel_r)
            2'd0:    raw_s = memif_rdata_in;
            2'd1:    raw_s = io_rdata_in;
            default: raw_s = alu_in;
        endcase
        case (alu_in[1:0])
            2'd0:    byte_s = raw_s[7:0];
            2'd1:    byte_s = raw_s[15:8];
            2'd2:    byte_s = raw_s[23:16];
            default: byte_s = raw_s[31:24];
        endcase
        if (alu_in[1]) begin
            half_s = raw_s[31:16];
        end else begin
            half_s = raw_s[15:0];
        end
        case (iw_in[14:12])
            3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
            3'b100:  load_s = {24'd0, byte_s};
            3'b001:  load_s = {{16{half_s[15]}}, half_s};
            3'b101:  load_s = {16'd0, half_s};
            default: load_s = raw_s;
        endcase
        if (is_load_s) begin
            wb_data_s = load_s;
        end else begin
            wb_data_s = alu_in;
        end
    end

    // x0 is hardwired to zero, so writes to it are suppressed here.
    assign wb_enable_s     = !reset && wb_en_in && (wb_reg_in != 5'd0);

    assign regif_wb_enable = wb_enable_s;
    assign regif_wb_reg    = wb_reg_in;
    assign regif_wb_data   = wb_data_s;
    assign df_wb_enable    = wb_enable_s;
    assign df_wb_reg       = wb_reg_in;
    assign df_wb_data      = wb_data_s;

    // Delayed forwarding tap covers the register-file write-then-read cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbd_enable_r <= 1'b0;
            wbd_reg_r    <= 5'd0;
            wbd_data_r   <= 32'd0;
        end else begin
            wbd_enable_r <= wb_enable_s;
            wbd_reg_r    <= wb_reg_in;
            wbd_data_r   <= wb_data_s;
        end
    end

    // Retired-instruction counter; bubbles (all-zero word) do not retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_r <= '0;
        end else if (iw_in != 32'd0) begin
            instret_r <= instret_r + INSTRET_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    assign df_wbd_enable = wbd_enable_r;
    assign df_wbd_reg    = wbd_reg_r;
    assign df_wbd_data   = wbd_data_r;
    assign instret       = instret_r;

endmodule
